// File: rtl/sha1_pkg.sv
//==============================================================================
// sha1_pkg : SHA-1 constants, core command bit positions and padder states
// Revision : 1.0
//==============================================================================
`default_nettype none

package sha1_pkg;

    localparam logic [31:0] H0 = 32'h6745_2301;
    localparam logic [31:0] H1 = 32'hEFCD_AB89;
    localparam logic [31:0] H2 = 32'h98BA_DCFE;
    localparam logic [31:0] H3 = 32'h1032_5476;
    localparam logic [31:0] H4 = 32'hC3D2_E1F0;

    localparam logic [31:0] K0 = 32'h5A82_7999;
    localparam logic [31:0] K1 = 32'h6ED9_EBA1;
    localparam logic [31:0] K2 = 32'h8F1B_BCDC;
    localparam logic [31:0] K3 = 32'hCA62_C1D6;

    localparam int CTL_READ  = 0;
    localparam int CTL_START = 1;
    localparam int CTL_CONT  = 2;
    localparam int ES_BUSY   = 3;

    typedef enum logic [2:0] {
        ST_FILL  = 3'd0,
        ST_PAD   = 3'd1,
        ST_START = 3'd2,
        ST_SEND  = 3'd3,
        ST_WAIT  = 3'd4,
        ST_READ  = 3'd5
    } pad_state_t;

    // Keep the first nbytes message bytes, mark the next with 0x80, zero the rest.
    function automatic logic [31:0] pad_partial(input logic [31:0] word,
                                                input logic [2:0]  nbytes);
        case (nbytes)
            3'd1:    pad_partial = {word[31:24], 8'h80, 16'h0000};
            3'd2:    pad_partial = {word[31:16], 8'h80, 8'h00};
            3'd3:    pad_partial = {word[31:8], 8'h80};
            default: pad_partial = word;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/sha1_block_buf.sv
//==============================================================================
// sha1_block_buf : 16 x 32-bit block buffer, one write port, one read port
// Revision       : 1.0
//==============================================================================
`default_nettype none

module sha1_block_buf (
    input  logic        clock,
    input  logic        wr_en,
    input  logic [3:0]  wr_idx,
    input  logic [31:0] wr_data,
    input  logic [3:0]  rd_idx,
    output logic [31:0] rd_data
);

    logic [31:0] mem [16];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

`default_nettype wire

// File: rtl/sha1_padder.sv
//==============================================================================
// sha1_padder : buffers, pads and feeds 512-bit blocks to the sha1 core
// Revision    : 1.0   (SHA1_PAD_BYTES_EN enables byte-granular messages)
//==============================================================================
`default_nettype none

module sha1_padder
    import sha1_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_last,
    input  logic [1:0]  in_bytes,
    output logic [31:0] core_source,
    output logic [2:0]  core_control,
    output logic        core_wenable,
    input  logic [3:0]  core_es,
    output logic        msg_done
);

    pad_state_t       state;
    logic [3:0]       idx;
    logic [3:0]       k;
    logic [LEN_W-1:0] length;
    logic             first_blk;
    logic             pad_done;
    logic             len_hi_done;
    logic             len_done;
    logic             msg_end;
    logic             seen_busy;
    logic             settled;

    logic             accept;
    logic [2:0]       nbytes;
    logic [LEN_W-1:0] len_inc;
    logic [63:0]      len64;
    logic             wr_en;
    logic [31:0]      wr_data;
    logic [3:0]       rd_idx;
    logic [31:0]      rd_data;
    logic [2:0]       start_ctl;
    logic [2:0]       read_ctl;
    logic             unused_es;

    assign unused_es = ^core_es[2:0];

`ifdef SHA1_PAD_BYTES_EN
    assign nbytes = (in_last && (in_bytes != 2'd0)) ? {1'b0, in_bytes} : 3'd4;
`else
    logic unused_bytes;
    assign unused_bytes = ^in_bytes;
    assign nbytes       = 3'd4;
`endif

    assign accept  = (state == ST_FILL) && in_valid && in_ready;
    assign len_inc = LEN_W'({nbytes, 3'b000});
    assign len64   = 64'(length);
    assign rd_idx  = (state == ST_SEND) ? (k + 4'd1) : 4'd0;

    always_comb begin
        start_ctl           = 3'b000;
        start_ctl[CTL_START] = 1'b1;
        start_ctl[CTL_CONT]  = ~first_blk;
        read_ctl            = 3'b000;
        read_ctl[CTL_READ]  = 1'b1;
    end

    // Pad word selection mirrors the flag updates in the PAD branch below.
    always_comb begin
        wr_en   = 1'b0;
        wr_data = 32'h0000_0000;
        if (accept) begin
            wr_en   = 1'b1;
            wr_data = pad_partial(in_data, nbytes);
        end else if (state == ST_PAD) begin
            wr_en = 1'b1;
            if (!pad_done) begin
                wr_data = 32'h8000_0000;
            end else if (idx == 4'd14) begin
                wr_data = len64[63:32];
            end else if ((idx == 4'd15) && len_hi_done) begin
                wr_data = len64[31:0];
            end
        end
    end

    sha1_block_buf u_buf (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_idx  (idx),
        .wr_data (wr_data),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_FILL;
            idx          <= 4'd0;
            k            <= 4'd0;
            length       <= '0;
            first_blk    <= 1'b1;
            pad_done     <= 1'b0;
            len_hi_done  <= 1'b0;
            len_done     <= 1'b0;
            msg_end      <= 1'b0;
            seen_busy    <= 1'b0;
            settled      <= 1'b0;
            in_ready     <= 1'b1;
            core_source  <= 32'h0000_0000;
            core_control <= 3'b000;
            core_wenable <= 1'b0;
            msg_done     <= 1'b0;
        end else begin
            core_wenable <= 1'b0;
            msg_done     <= 1'b0;
            case (state)
                ST_FILL: begin
                    if (accept) begin
                        length <= length + len_inc;
                        idx    <= idx + 4'd1;
                        if (in_last) begin
                            msg_end  <= 1'b1;
                            pad_done <= (nbytes != 3'd4);
                        end
                        if (idx == 4'd15) begin
                            in_ready     <= 1'b0;
                            state        <= ST_START;
                            core_wenable <= 1'b1;
                            core_control <= start_ctl;
                        end else if (in_last) begin
                            in_ready <= 1'b0;
                            state    <= ST_PAD;
                        end
                    end
                end
                ST_PAD: begin
                    idx <= idx + 4'd1;
                    if (!pad_done) begin
                        pad_done <= 1'b1;
                    end else if (idx == 4'd14) begin
                        len_hi_done <= 1'b1;
                    end else if ((idx == 4'd15) && len_hi_done) begin
                        len_done <= 1'b1;
                    end
                    if (idx == 4'd15) begin
                        state        <= ST_START;
                        core_wenable <= 1'b1;
                        core_control <= start_ctl;
                    end
                end
                ST_START: begin
                    core_control <= 3'b000;
                    core_source  <= rd_data;
                    k            <= 4'd0;
                    first_blk    <= 1'b0;
                    state        <= ST_SEND;
                end
                ST_SEND: begin
                    if (k == 4'd15) begin
                        core_source <= 32'h0000_0000;
                        state       <= ST_WAIT;
                    end else begin
                        core_source <= rd_data;
                        k           <= k + 4'd1;
                    end
                end
                // Busy must have risen and then stayed low for two cycles.
                ST_WAIT: begin
                    if (core_es[ES_BUSY]) begin
                        seen_busy <= 1'b1;
                        settled   <= 1'b0;
                    end else if (seen_busy) begin
                        if (!settled) begin
                            settled <= 1'b1;
                        end else begin
                            seen_busy <= 1'b0;
                            settled   <= 1'b0;
                            if (len_done) begin
                                state        <= ST_READ;
                                core_wenable <= 1'b1;
                                core_control <= read_ctl;
                                msg_done     <= 1'b1;
                            end else if (msg_end) begin
                                state <= ST_PAD;
                            end else begin
                                state    <= ST_FILL;
                                in_ready <= 1'b1;
                            end
                        end
                    end
                end
                ST_READ: begin
                    core_control <= 3'b000;
                    first_blk    <= 1'b1;
                    length       <= '0;
                    pad_done     <= 1'b0;
                    len_hi_done  <= 1'b0;
                    len_done     <= 1'b0;
                    msg_end      <= 1'b0;
                    idx          <= 4'd0;
                    in_ready     <= 1'b1;
                    state        <= ST_FILL;
                end
                default: begin
                    state <= ST_FILL;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sha1_padder.sv
//==============================================================================
// tb_sha1_padder : random and directed messages checked against FIPS padding
// Revision       : 1.0
//==============================================================================
`default_nettype none

module tb_sha1_padder;

`ifdef SHA1_PAD_BYTES_EN
    localparam bit BYTES_EN = 1'b1;
`else
    localparam bit BYTES_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_last = 1'b0;
    logic [1:0]  in_bytes = '0;
    logic [31:0] core_source;
    logic [2:0]  core_control;
    logic        core_wenable;
    logic [3:0]  core_es;
    logic        msg_done;

    always #5 clock = ~clock;

    sha1_padder #(.LEN_W(64)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_last      (in_last),
        .in_bytes     (in_bytes),
        .core_source  (core_source),
        .core_control (core_control),
        .core_wenable (core_wenable),
        .core_es      (core_es),
        .msg_done     (msg_done)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Core stand-in: captures 16 words after each start, then reports busy.
    logic        busy = 1'b0;
    logic [1:0]  bhist = 2'b00;
    int          busy_left = 0;
    int          cap_left = 0;
    int          cur_k = -1;
    int          readouts = 0;
    logic [31:0] cap_q[$];
    logic [2:0]  ctl_q[$];

    assign core_es = {busy, 3'b000};

    always @(negedge clock) begin
        if (reset) begin
            busy      = 1'b0;
            bhist     = 2'b00;
            busy_left = 0;
            cap_left  = 0;
            cur_k     = -1;
        end else begin
            if (busy_left > 0) begin
                busy = 1'b1;
                busy_left--;
            end else begin
                busy = 1'b0;
            end
            cur_k = -1;
            if (cap_left > 0) begin
                cur_k = 16 - cap_left;
                cap_q.push_back(core_source);
                cap_left--;
                chk("in_ready_while_sending", 64'(in_ready), 64'd0);
            end
            if (core_wenable) chk("wenable_near_busy", 64'({busy, bhist}), 64'd0);
            if (core_wenable && core_control[1]) begin
                ctl_q.push_back(core_control);
                cap_left  = 16;
                busy_left = 16 + int'($urandom_range(1, 12));
            end
            if (core_wenable && core_control == 3'b001) readouts++;
            if (msg_done || (core_wenable && core_control == 3'b001))
                chk("msg_done_with_readout", 64'({msg_done, core_wenable, core_control}), 64'b11001);
            bhist = {bhist[0], busy};
        end
    end

    logic [31:0] msg_q[$];
    logic [31:0] exp_q[$];

    // Byte-level FIPS 180-1 padding of the message held in msg_q.
    task automatic build_ref(input int lastb);
        logic [7:0]  b[$];
        logic [63:0] bits;
        int          nb;
        exp_q.delete();
        for (int i = 0; i < msg_q.size(); i++) begin
            nb = (i == msg_q.size() - 1) ? lastb : 4;
            for (int j = 0; j < nb; j++) b.push_back(msg_q[i][31-8*j -: 8]);
        end
        bits = 64'(b.size()) * 64'd8;
        b.push_back(8'h80);
        while (b.size() % 64 != 56) b.push_back(8'h00);
        for (int j = 7; j >= 0; j--) b.push_back(bits[8*j +: 8]);
        for (int i = 0; i < b.size(); i += 4)
            exp_q.push_back({b[i], b[i+1], b[i+2], b[i+3]});
    endtask

    task automatic send_words(input int lastb, input bit gaps, input bit mark_last);
        int t;
        bit acc;
        for (int i = 0; i < msg_q.size(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(negedge clock);
            end
            in_data  = msg_q[i];
            in_valid = 1'b1;
            in_last  = mark_last && (i == msg_q.size() - 1);
            if (BYTES_EN && in_last) in_bytes = (lastb == 4) ? 2'd0 : 2'(lastb);
            else                     in_bytes = 2'($urandom_range(0, 3));
            t = 0;
            do begin
                acc = in_ready;
                @(negedge clock);
                t++;
            end while (!acc && t < 3000);
            if (!acc) begin
                chk("accept_timeout", 64'(acc), 64'd1);
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    function automatic logic [31:0] capw(input int i);
        return (i < cap_q.size()) ? cap_q[i] : 32'hxxxx_xxxx;
    endfunction

    // Send one message, wait for its read-out, compare every block word.
    task automatic run_msg(input string tag, input int lastb, input bit gaps);
        int r0;
        int t;
        build_ref(lastb);
        cap_q.delete();
        ctl_q.delete();
        r0 = readouts;
        send_words(lastb, gaps, 1'b1);
        t = 0;
        while (readouts == r0 && t < 5000) begin
            @(negedge clock);
            t++;
        end
        repeat (8) @(negedge clock);
        chk({tag, "_readouts"}, 64'(readouts - r0), 64'd1);
        chk({tag, "_nwords"}, 64'(cap_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s_w%0d", tag, i), 64'(capw(i)), 64'(exp_q[i]));
        chk({tag, "_nstarts"}, 64'(ctl_q.size()), 64'(exp_q.size() / 16));
        for (int i = 0; i < ctl_q.size(); i++)
            chk($sformatf("%s_ctl%0d", tag, i), 64'(ctl_q[i]), (i == 0) ? 64'b010 : 64'b110);
    endtask

    task automatic single_word_msg(input string tag);
        msg_q.delete();
        if (BYTES_EN) begin
            msg_q.push_back(32'h6162_6300);
            run_msg(tag, 3, 1'b0);
            chk({tag, "_first"}, 64'(capw(0)), 64'h6162_6380);
            chk({tag, "_len"}, 64'(capw(15)), 64'h0000_0018);
        end else begin
            msg_q.push_back(32'hDEAD_BEEF);
            run_msg(tag, 4, 1'b0);
            chk({tag, "_first"}, 64'(capw(0)), 64'hDEAD_BEEF);
            chk({tag, "_marker"}, 64'(capw(1)), 64'h8000_0000);
            chk({tag, "_len"}, 64'(capw(15)), 64'h0000_0020);
        end
    endtask

    task automatic fill_random(input int n);
        msg_q.delete();
        for (int i = 0; i < n; i++) msg_q.push_back($urandom);
    endtask

    initial begin
        int t;
        int nw;
        int lb;

        repeat (3) @(negedge clock);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_source", 64'(core_source), 64'd0);
        chk("rst_control", 64'(core_control), 64'd0);
        chk("rst_wenable", 64'(core_wenable), 64'd0);
        chk("rst_msg_done", 64'(msg_done), 64'd0);
        reset = 1'b0;
        @(negedge clock);

        single_word_msg("one_word");

        fill_random(14);
        run_msg("w14", 4, 1'b1);
        chk("w14_marker", 64'(capw(14)), 64'h8000_0000);
        chk("w14_pad15", 64'(capw(15)), 64'h0);
        chk("w14_len", 64'(capw(31)), 64'h0000_01C0);

        fill_random(16);
        run_msg("w16", 4, 1'b1);
        chk("w16_marker", 64'(capw(16)), 64'h8000_0000);
        chk("w16_len", 64'(capw(31)), 64'h0000_0200);

        // Continuous valid with no gaps exercises hold-off across blocks.
        fill_random(40);
        run_msg("backpressure", 4, 1'b0);

        for (int m = 0; m < 6; m++) begin
            nw = int'($urandom_range(1, 36));
            lb = BYTES_EN ? int'($urandom_range(1, 4)) : 4;
            fill_random(nw);
            run_msg($sformatf("rand%0d", m), lb, 1'b1);
        end

        // Abort a block mid-transfer with reset.
        fill_random(16);
        cap_q.delete();
        ctl_q.delete();
        send_words(4, 1'b0, 1'b0);
        t = 0;
        do begin
            @(negedge clock);
            #1;
            t++;
        end while (cur_k != 7 && t < 200);
        chk("reached_word7", 64'(cur_k), 64'd7);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        #1;
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_source", 64'(core_source), 64'd0);
        chk("abort_control", 64'(core_control), 64'd0);
        chk("abort_wenable", 64'(core_wenable), 64'd0);
        chk("abort_msg_done", 64'(msg_done), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        cap_q.delete();
        ctl_q.delete();
        repeat (40) @(negedge clock);
        chk("idle_after_abort", 64'(ctl_q.size()), 64'd0);

        single_word_msg("after_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
